// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_sequencer_pkg;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGE_GAP   = 4;
    localparam int DEF_ACK_TIMEOUT = 64;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2,
        IDLE     = 2'd3
    } seq_state_t;

    // One extra bit over the largest terminal value so the shared counter never wraps.
    function automatic int cnt_width(input int hold, input int gap, input int tmo);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (tmo > m) m = tmo;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/acknowledge and status bundle between the sequencer and the reset domains it drives.
interface reset_sequencer_if
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  rst_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  all_ready;
    logic                  busy;
    logic                  err_timeout;
    logic [IDX_W-1:0]      err_stage;

    modport master (
        input  rst_req,
        input  stage_ack,
        output stage_rst,
        output all_ready,
        output busy,
        output err_timeout,
        output err_stage
    );

    modport slave (
        output rst_req,
        output stage_ack,
        input  stage_rst,
        input  all_ready,
        input  busy,
        input  err_timeout,
        input  err_stage
    );

endinterface

// File: rtl/reset_sequencer_timer.sv
// Clearable up-counter that stops at a supplied terminal value and flags when it is there.
module rst_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = (cnt == term);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (!done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Stretches reset requests to a minimum width, then releases reset domains in index order with ack handshakes.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              srst,
    reset_sequencer_if.master bus
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  all_ready;
    logic                  busy;
    logic                  err_timeout;
    logic [IDX_W-1:0]      err_stage;

    logic                  restart;
    logic                  ack_cur;
    logic                  done;
    logic                  clr;
    logic [CNT_W-1:0]      term;

    assign restart = srst || bus.rst_req;
    assign ack_cur = bus.stage_ack[idx];
    assign idx_nxt = idx + 1'b1;

    always_comb begin
        term = '0;
        case (state)
            HOLD:     term = CNT_W'(HOLD_CYCLES - 1);
            WAIT_ACK: term = CNT_W'(ACK_TIMEOUT - 1);
            GAP:      term = CNT_W'(STAGE_GAP - 1);
            default:  term = '0;
        endcase
    end

    // Counter restarts on every state change; IDLE keeps it parked at zero.
    assign clr = restart || done || (state == WAIT_ACK && ack_cur) || (state == IDLE);

    rst_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .clr  (clr),
        .term (term),
        .done (done)
    );

    always_ff @(posedge clk) begin
        if (restart) begin
            state       <= HOLD;
            idx         <= '0;
            stage_rst   <= '1;
            all_ready   <= 1'b0;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            err_stage   <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (done) begin
                        stage_rst[0] <= 1'b0;
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_cur || done) begin
                        // An ack on the terminal edge wins over the timeout.
                        if (!ack_cur) begin
                            err_timeout <= 1'b1;
                            if (!err_timeout) begin
                                err_stage <= idx;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state     <= IDLE;
                            all_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (done) begin
                        idx                <= idx_nxt;
                        stage_rst[idx_nxt] <= 1'b0;
                        state              <= WAIT_ACK;
                    end
                end
                IDLE: begin
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.stage_rst   = stage_rst;
    assign bus.all_ready   = all_ready;
    assign bus.busy        = busy;
    assign bus.err_timeout = err_timeout;
    assign bus.err_stage   = err_stage;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Single-clock reset sequencer that sits upstream of the per-block reset inputs. It generates a reset of guaranteed minimum width from a synchronous request, then releases NUM_STAGES downstream reset domains one at a time, in index order. Before releasing the next domain it waits for a ready acknowledge from the previous one, with a timeout. This closes the short-pulse hazard of synchronous resets by stretching every request to HOLD_CYCLES.

## Interface
- NUM_STAGES, 4: number of sequenced reset outputs; at least 1.
- HOLD_CYCLES, 16: minimum cycles all outputs stay asserted after the last request; at least 1.
- STAGE_GAP, 4: cycles between an acknowledge and the next stage's release; at least 1.
- ACK_TIMEOUT, 64: cycles to wait for an acknowledge before flagging an error; at least 1.
- clk, input, 1: clock.
- srst, input, 1: synchronous, active-high reset.
- rst_req, input, 1: synchronous reset request, level-sensitive, any width.
- stage_ack, input, NUM_STAGES: per-stage ready. Already synchronous to clk; sampled only for the stage currently awaited.
- stage_rst, output, NUM_STAGES: per-stage reset, active-high.
- all_ready, output, 1: every stage is released and the sequence is complete.
- busy, output, 1: the sequencer is not in IDLE.
- err_timeout, output, 1: sticky flag; at least one stage timed out in the current sequence.
- err_stage, output, $clog2(NUM_STAGES) bits (minimum 1): index of the first stage that timed out.

## Operation
- States: HOLD, WAIT_ACK, GAP, IDLE. A stage index idx runs 0..NUM_STAGES-1, and one shared counter cnt serves every state.
- srst high at an edge:
  - stage_rst becomes all ones, all_ready 0, err_timeout 0, err_stage 0.
  - State becomes HOLD, cnt 0, idx 0, busy 1.
- HOLD:
  - rst_req high resets cnt to 0.
  - Otherwise cnt increments. On the edge where cnt == HOLD_CYCLES-1, stage_rst[0] goes to 0, state becomes WAIT_ACK, cnt 0.
- WAIT_ACK(idx):
  - If stage_ack[idx] is high, the stage is done.
  - Otherwise, on the edge where cnt == ACK_TIMEOUT-1, the stage is done with a timeout. err_timeout is set to 1, and err_stage is set to idx only if err_timeout was 0.
  - Otherwise cnt increments.
  - When the stage is done: if idx is the last stage, state becomes IDLE and all_ready goes to 1. Otherwise state becomes GAP, cnt 0.
- GAP: on the edge where cnt == STAGE_GAP-1, idx increments, stage_rst[idx] goes to 0, state becomes WAIT_ACK, cnt 0. Otherwise cnt increments.
- IDLE: holds its outputs until rst_req is high.
- rst_req high in any state:
  - Same effect as srst, except srst always takes priority.
  - Stages already released are reasserted immediately, at that edge.
- Priority at any single edge: srst, then rst_req, then ack/timeout, then the counter.
- A released stage is never reasserted except by srst or rst_req.
- stage_ack is ignored for stages other than idx, and in every state other than WAIT_ACK.
- busy is 1 in every state except IDLE.

## Timing
- All outputs are registered. Each output changes only on the clk edge at which its state transition occurs.
- Reset values: stage_rst all ones, all_ready 0, busy 1, err_timeout 0, err_stage 0.
- Let edge 0 be the last edge at which srst or rst_req is sampled high.
- Release timeline:
  - stage_rst[0] falls at edge HOLD_CYCLES.
  - An ack sampled at edge A releases the next stage at edge A+STAGE_GAP.
  - An ack present at the release edge itself is not counted; the earliest ack is sampled at release+1.
- Timeout fires at edge release+ACK_TIMEOUT if no ack was seen at edges release+1 through release+ACK_TIMEOUT. An ack at that same edge counts as an ack, not a timeout.
- cnt width is $clog2 of the largest of HOLD_CYCLES, STAGE_GAP and ACK_TIMEOUT, plus 1. The counter never wraps.

## Structure
- Package reset_sequencer_pkg holds:
  - the state enum (HOLD, WAIT_ACK, GAP, IDLE);
  - a function giving the counter width from the three parameters;
  - localparam defaults.
- One sub-module, rst_seq_timer: a clearable up-counter with a terminal-compare input. The FSM supplies the terminal value for the current state (HOLD_CYCLES-1, STAGE_GAP-1 or ACK_TIMEOUT-1) and gets a done pulse back.
- The top module contains the FSM, the idx register and the output registers.

## Test plan
All cases use default parameters.
- **srst, all stage_ack tied high.** Measured from edge 0:
  - stage_rst bits 0, 1, 2, 3 fall at edges 16, 21, 26 and 31;
  - all_ready rises and busy falls at edge 32.
- **rst_req held high for 10 cycles while in IDLE.**
  - Output 0xF, all_ready 0 from the first high edge.
  - stage_rst[0] falls 16 edges after the last high edge.
- **stage_ack[2] never asserted, others tied high.**
  - err_timeout rises and err_stage becomes 2 at edge 26+64=90.
  - stage_rst[3] falls at edge 94; all_ready rises at edge 95.
- **rst_req pulsed for one cycle during GAP after stage 1 released.**
  - stage_rst returns to 0xF and err_timeout clears at that edge.
  - The full sequence restarts with the same timing as scenario 1.
- **Simultaneous events.**
  - rst_req and stage_ack[idx] both high in WAIT_ACK: rst_req wins.
  - srst and rst_req both high: same result as srst alone.
  - stage_ack[3] pulsed during WAIT_ACK for stage 1: ignored, with no early release.
